// File: rtl/key_onehot_latch_if.sv
// Key front-end bus: raw key levels and clear in, latched one-hot code and status pulses out.
// key_valid is a level that qualifies onehot_out; key_event and multi_err are single-cycle pulses with no ready.
interface key_onehot_latch_if #(
  parameter int N_KEYS = 8
);
  logic [N_KEYS-1:0] key_in;
  logic              clr;
  logic [N_KEYS-1:0] onehot_out;
  logic              key_valid;
  logic              key_event;
  logic              multi_err;

  modport master (
    output key_in, clr,
    input  onehot_out, key_valid, key_event, multi_err
  );

  modport slave (
    input  key_in, clr,
    output onehot_out, key_valid, key_event, multi_err
  );
endinterface

// File: rtl/key_onehot_latch.sv
// Synchronises and debounces raw key lines, detects presses and latches a one-hot code
// that is always zero or exactly one-hot, with event and multi-press error pulses.
module key_onehot_latch #(
  parameter int N_KEYS       = 8,
  parameter int DEBOUNCE_CYC = 20,
  parameter int CNT_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  key_onehot_latch_if.slave  bus,
  output logic               dbg_state
);

  typedef enum logic {IDLE = 1'b0, LATCHED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] db_q, db_d, db_dly_q;
  logic [N_KEYS-1:0] arm_q, arm_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [1:0]        warm_q;
  logic [N_KEYS-1:0] press;
  logic              press_one, press_multi;

  state_t            state_q, state_d;
  logic [N_KEYS-1:0] onehot_q, onehot_d;
  logic              event_q, event_d;
  logic              err_q, err_d;

  // Debounce: a key must disagree with its stable level for DEBOUNCE_CYC cycles in a row.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = ~db_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // A key is armed only once it has been seen released after reset, so keys held
  // through reset produce no event until they are released and pressed again.
  always_comb begin
    arm_d       = arm_q | ({N_KEYS{warm_q[1]}} & ~sync2_q & ~db_q);
    press       = db_q & ~db_dly_q & arm_q;
    press_one   = (press != '0) && ((press & (press - N_KEYS'(1))) == '0);
    press_multi = (press != '0) && !press_one;
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    event_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          onehot_d = '0;
        end else if (press_one) begin
          onehot_d = press;
          event_d  = 1'b1;
          state_d  = LATCHED;
        end else if (press_multi) begin
          err_d = 1'b1;
        end
      end
      LATCHED: begin
        if (bus.clr) begin
          onehot_d = '0;
          state_d  = IDLE;
        end else if (press_one) begin
          onehot_d = press;
          event_d  = 1'b1;
        end else if (press_multi) begin
          err_d = 1'b1;
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      arm_q    <= '0;
      warm_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      state_q  <= IDLE;
      onehot_q <= '0;
      event_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= bus.key_in;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      arm_q    <= arm_d;
      warm_q   <= {warm_q[0], 1'b1};
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      onehot_q <= onehot_d;
      event_q  <= event_d;
      err_q    <= err_d;
    end
  end

  assign bus.onehot_out = onehot_q;
  assign bus.key_valid  = (state_q == LATCHED);
  assign bus.key_event  = event_q;
  assign bus.multi_err  = err_q;
  assign dbg_state      = state_q;

endmodule
